key_schedule: RTL and testbench

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/key_byte_sel.sv | 26 ++
 rtl/key_schedule.sv | 171 +++++++++++++++++
 tb/tb_key_schedule.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types for the RC4 key-schedule block.
// Holds the byte type, the key-schedule state encoding, the default key
// length and the j-update helper used by the FSM datapath.
package rc4_pkg;

    localparam int KEY_LEN_DEFAULT = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_I   = 4'd1,
        WAIT_I = 4'd2,
        RD_J   = 4'd3,
        WAIT_J = 4'd4,
        WR_I   = 4'd5,
        WR_J   = 4'd6,
        NEXT   = 4'd7,
        DONE   = 4'd8
    } ksa_state_e;

    // j' = j + S[i] + key byte, modulo 256 (carries fall off the 8-bit result)
    function automatic byte_t next_j(input byte_t j, input byte_t si, input byte_t kb);
        byte_t sum;
        sum = j + si + kb;
        return sum;
    endfunction

endpackage

// File: rtl/key_byte_sel.sv
// key_byte_sel: picks key byte number idx_i out of the packed key vector.
// Key byte 0 sits in the most significant byte of key_i.
module key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEFAULT,
    parameter int IDX_W   = 2
) (
    input  logic [8*KEY_LEN-1:0] key_i,
    input  logic [IDX_W-1:0]     idx_i,
    output byte_t                key_byte_o
);

    byte_t sel_s;

    // AND-OR mux over the key bytes; an out-of-range index yields zero
    always_comb begin
        sel_s = 8'h00;
        for (int b = 0; b < KEY_LEN; b++) begin
            sel_s = sel_s | ((idx_i == IDX_W'(b)) ? key_i[8*(KEY_LEN-1-b) +: 8] : 8'h00);
        end
    end

    assign key_byte_o = sel_s;

endmodule

// File: rtl/key_schedule.sv
// key_schedule: RC4 key-scheduling pass over an external 256-byte S memory
// (synchronous read, data on q one cycle after addr). Each iteration reads
// S[i], updates j, reads S[j] and writes both back swapped.
// Build option KSA_SELF_SWAP_SKIP_EN: when the new j equals i the swap is a
// no-op, so the iteration jumps straight from WAIT_I to NEXT.
module key_schedule
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] key,
    input  logic [7:0]           q,
    output logic [7:0]           addr,
    output logic [7:0]           data,
    output logic                 wren,
    output logic                 done
);

    localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    ksa_state_e           state_q, state_d;
    byte_t                i_q, i_d, j_q, j_d;
    byte_t                si_q, si_d, sj_q, sj_d;
    logic [IDX_W-1:0]     kidx_q, kidx_d;
    logic [8*KEY_LEN-1:0] key_q, key_d;
    logic                 start_q;
    byte_t                addr_q, addr_d, data_q, data_d;
    logic                 wren_q, wren_d, done_q, done_d;
    byte_t                kbyte_s, j_new_s;
    logic                 start_edge_s;

    key_byte_sel #(
        .KEY_LEN (KEY_LEN),
        .IDX_W   (IDX_W)
    ) u_key_byte_sel (
        .key_i      (key_q),
        .idx_i      (kidx_q),
        .key_byte_o (kbyte_s)
    );

    assign start_edge_s = start & ~start_q;
    assign j_new_s      = next_j(j_q, q, kbyte_s);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; start edges are only honoured in IDLE and DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_edge_s ? RD_I : IDLE;
            RD_I:    state_d = WAIT_I;
`ifdef KSA_SELF_SWAP_SKIP_EN
            WAIT_I:  state_d = (j_new_s == i_q) ? NEXT : RD_J;
`else
            WAIT_I:  state_d = RD_J;
`endif
            RD_J:    state_d = WAIT_J;
            WAIT_J:  state_d = WR_I;
            WR_I:    state_d = WR_J;
            WR_J:    state_d = NEXT;
            NEXT:    state_d = (i_q == 8'hFF) ? DONE : RD_I;
            DONE:    state_d = start_edge_s ? RD_I : DONE;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: index/key capture, j update, S[i]/S[j] latches
    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        si_d   = si_q;
        sj_d   = sj_q;
        kidx_d = kidx_q;
        key_d  = key_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge_s) begin
                    key_d  = key;
                    i_d    = 8'h00;
                    j_d    = 8'h00;
                    kidx_d = '0;
                end else begin
                    key_d  = key_q;
                end
            end
            WAIT_I: begin
                si_d = q;
                j_d  = j_new_s;
            end
            WAIT_J: begin
                sj_d = q;
            end
            NEXT: begin
                i_d    = i_q + 8'd1;
                kidx_d = (kidx_q == IDX_W'(KEY_LEN - 1)) ? '0 : kidx_q + IDX_W'(1);
            end
            default: begin
                i_d = i_q;
            end
        endcase
    end

    // memory-port and done outputs, computed for the state being entered so
    // the registered outputs line up with the state they belong to
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        wren_d = 1'b0;
        done_d = (state_q == DONE) && (state_d == DONE);
        case (state_d)
            RD_I:    addr_d = i_d;
            RD_J:    addr_d = j_d;
            WR_I: begin
                addr_d = i_q;
                data_d = sj_d;
                wren_d = 1'b1;
            end
            WR_J: begin
                addr_d = j_q;
                data_d = si_q;
                wren_d = 1'b1;
            end
            default: addr_d = addr_q;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
            kidx_q  <= '0;
            key_q   <= '0;
            start_q <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
            start_q <= start;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
        end
    end

    assign addr = addr_q;
    assign data = data_q;
    assign wren = wren_q;
    assign done = done_q;

endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule: scoreboard bench for key_schedule with a behavioural
// synchronous-read S memory. A software KSA model queues the expected writes
// and final S; a monitor checks every write the DUT issues.
module tb_key_schedule;
    import rc4_pkg::*;

    localparam int KL = 3;
`ifdef KSA_SELF_SWAP_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [8*KL-1:0] key;
    logic [7:0]    q;
    logic [7:0]    addr;
    logic [7:0]    data;
    logic          wren;
    logic          done;

    key_schedule #(.KEY_LEN(KL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .key   (key),
        .q     (q),
        .addr  (addr),
        .data  (data),
        .wren  (wren),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic       init_req = 1'b0;
    int         cyc = 0;

    // behavioural S memory: synchronous read, write on wren, identity preload
    always @(posedge clk) begin
        q   <= mem[addr];
        cyc <= cyc + 1;
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren) begin
            mem[addr] <= data;
        end
    end

    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];
    logic [7:0] exp_s [256];
    int         exp_cycles;
    int         compared = 0;
    int         mismatched = 0;
    int         c0;
    bit         log_en = 1'b0;
    int         wlog_n = 0;
    logic [7:0] wlog_a [4];
    logic [7:0] wlog_d [4];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // software RC4 KSA on identity S; queues expected writes and final S
    task automatic model_pass(input logic [8*KL-1:0] k);
        logic [7:0]      s [256];
        logic [7:0]      j, t, kb;
        logic [8*KL-1:0] sh;
        int              cycles;
        exp_a.delete();
        exp_d.delete();
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        j = 8'h00;
        cycles = 0;
        for (int i = 0; i < 256; i++) begin
            sh = k >> (8 * (KL - 1 - (i % KL)));
            kb = sh[7:0];
            j  = j + s[i] + kb;
            if (SKIP && (j == i[7:0])) begin
                cycles += 3;
            end else begin
                exp_a.push_back(i[7:0]); exp_d.push_back(s[j]);
                exp_a.push_back(j);      exp_d.push_back(s[i]);
                t = s[i]; s[i] = s[j]; s[j] = t;
                cycles += 7;
            end
        end
        exp_s = s;
        exp_cycles = cycles + 1;
    endtask

    // monitor: every DUT write must match the head of the expected queue
    always @(negedge clk) begin
        logic [7:0] ea, ed;
        if (rst_n === 1'b1 && wren === 1'b1) begin
            if (exp_a.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", addr, data);
            end else begin
                ea = exp_a.pop_front();
                ed = exp_d.pop_front();
                check("write_addr", addr, ea);
                check("write_data", data, ed);
            end
            if (log_en && wlog_n < 4) begin
                wlog_a[wlog_n] = addr;
                wlog_d[wlog_n] = data;
                wlog_n++;
            end
        end
    end

    // preload identity S, build the model, and issue one start rising edge
    task automatic launch(input logic [8*KL-1:0] k);
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
        model_pass(k);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        c0    = cyc;
        start = 1'b0;
        check("done_clear_on_start", done, 0);
    endtask

    // bounded wait for done, then check timing, drained queue and final S
    task automatic wait_done(input string tag);
        int bad;
        while (done !== 1'b1 && (cyc - c0) < 4000) @(negedge clk);
        check({tag, "_done_high"}, done, 1);
        check({tag, "_done_cycle"}, cyc - c0, exp_cycles);
        check({tag, "_writes_left"}, exp_a.size(), 0);
        bad = 0;
        for (int x = 0; x < 256; x++) if (mem[x] !== exp_s[x]) bad++;
        check({tag, "_final_s_bad_bytes"}, bad, 0);
    endtask

    initial begin
        int low;
        rst_n = 1'b0;
        start = 1'b0;
        key   = '0;
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_wren", wren, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // key 0A1B2C: hand-computed first two iterations
        log_en = 1'b1;
        launch(24'h0A1B2C);
        wait_done("k0a1b2c");
        log_en = 1'b0;
        check("it0_wr_i_addr", wlog_a[0], 8'h00);
        check("it0_wr_i_data", wlog_d[0], 8'h0A);
        check("it0_wr_j_addr", wlog_a[1], 8'h0A);
        check("it0_wr_j_data", wlog_d[1], 8'h00);
        check("it1_wr_i_addr", wlog_a[2], 8'h01);
        check("it1_wr_i_data", wlog_d[2], 8'h26);
        check("it1_wr_j_addr", wlog_a[3], 8'h26);
        check("it1_wr_j_data", wlog_d[3], 8'h01);

        // key 000249 with a start pulse and key change near iteration 50
        launch(24'h000249);
        while ((cyc - c0) < 350) @(negedge clk);
        start = 1'b1;
        key   = 24'hFFFFFF;
        @(negedge clk) start = 1'b0;
        wait_done("k000249_pulse");
        low = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b1) low++;
        end
        check("done_hold_low_cycles", low, 0);

        // key 000000: iteration 0 has i == j
        launch(24'h000000);
        wait_done("k000000");

        // reset near iteration 100
        launch(24'h0A1B2C);
        while ((cyc - c0) < 700) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wren", wren, 0);
        check("midrst_done", done, 0);
        check("midrst_addr", addr, 0);
        check("midrst_state_idle", int'(dut.state_q), int'(IDLE));
        exp_a.delete();
        exp_d.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_done", done, 0);
        check("postrst_state_idle", int'(dut.state_q), int'(IDLE));
        launch(24'h000249);
        wait_done("k000249_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
